// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: slice/stage helpers shared by the pipelined adder family.
package pipe_adder_pkg;
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;
   function automatic bit cfg_ok(input int width, input int stages);
      return width >= 1 && stages >= 1 && stages <= width && width % stages == 0;
   endfunction
   function automatic int slice_width(input int width, input int stages);
      return stages >= 1 ? width / stages : width;
   endfunction
   function automatic int slice_lo(input int k, input int slice);
      return k * slice;
   endfunction
endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result stream bundle for pipe_adder.
// PIPE_ADDER_OVF_EN adds the ovf result signal.
interface pipe_adder_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;
   modport master (output in_valid, a, b, c_in, out_ready,
                   input  in_ready, out_valid, sum, c_out, ovf);
   modport slave  (input  in_valid, a, b, c_in, out_ready,
                   output in_ready, out_valid, sum, c_out, ovf);
`else
   modport master (output in_valid, a, b, c_in, out_ready,
                   input  in_ready, out_valid, sum, c_out);
   modport slave  (input  in_valid, a, b, c_in, out_ready,
                   output in_ready, out_valid, sum, c_out);
`endif
endinterface

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one SLICE-bit slice of the pipelined adder with its carry and valid registers.
module pipe_adder_stage
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_WIDTH / DEF_STAGES,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             c_i,
   output logic             v_o,
   output logic [WIDTH-1:0] x_o,
   output logic [WIDTH-1:0] y_o,
   output logic             c_o
);
   localparam int LO = slice_lo(K, SLICE);
   localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} << (LO + SLICE);
   logic             v_q;
   logic             c_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] x_d;
   logic [SLICE:0]   s;
   assign s = {1'b0, x_i[LO +: SLICE]} + {1'b0, y_i[LO +: SLICE]} + {{SLICE{1'b0}}, c_i};
   // x: finished sum bits below the slice top, untouched A bits above; y: only unconsumed B bits
   always_comb begin
      x_d = x_i;
      x_d[LO +: SLICE] = s[SLICE-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= 1'b0;
         c_q <= 1'b0;
         x_q <= '0;
         y_q <= '0;
      end else if (ld_i) begin
         v_q <= v_i;
         if (v_i) begin
            x_q <= x_d;
            y_q <= y_i & KEEP;
            c_q <= s[SLICE];
         end
      end
   end
   assign v_o = v_q;
   assign x_o = x_q;
   assign y_o = y_q;
   assign c_o = c_q;
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder, one slice per stage, valid/ready on both sides.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input logic         clk,
   input logic         rst_n,
   pipe_adder_if.slave bus
);
   localparam int SLICE = slice_width(WIDTH, STAGES);
   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_adder: illegal WIDTH/STAGES combination");
   end
   logic [STAGES:0]  v_s;
   logic [STAGES:0]  c_s;
   logic [STAGES:0]  rdy;
   logic [WIDTH-1:0] x_s [STAGES+1];
   logic [WIDTH-1:0] y_s [STAGES+1];
   logic [WIDTH-1:0] sum_w;
   assign v_s[0] = bus.in_valid;
   assign c_s[0] = bus.c_in;
   assign x_s[0] = bus.a;
   assign y_s[0] = bus.b;
   // stage k sits between v_s[k] (its input) and v_s[k+1] (its register)
   always_comb begin
      rdy = '0;
      rdy[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !v_s[k+1] || rdy[k+1];
   end
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(.WIDTH(WIDTH), .SLICE(SLICE), .K(k)) u_stage (
         .clk  (clk),
         .rst_n(rst_n),
         .ld_i (rdy[k]),
         .v_i  (v_s[k]),
         .x_i  (x_s[k]),
         .y_i  (y_s[k]),
         .c_i  (c_s[k]),
         .v_o  (v_s[k+1]),
         .x_o  (x_s[k+1]),
         .y_o  (y_s[k+1]),
         .c_o  (c_s[k+1])
      );
   end
   // every B slice is consumed by now, so y_s[STAGES] is all-zero
   assign sum_w         = x_s[STAGES] | y_s[STAGES];
   assign bus.sum       = sum_w;
   assign bus.c_out     = c_s[STAGES];
   assign bus.out_valid = v_s[STAGES];
   assign bus.in_ready  = rdy[0];
`ifdef PIPE_ADDER_OVF_EN
   logic p_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) p_q <= 1'b0;
      else if (rdy[STAGES-1] && v_s[STAGES-1]) p_q <= x_s[STAGES-1][WIDTH-1] ^ y_s[STAGES-1][WIDTH-1];
   end
   // carry into the MSB is a^b^sum at that bit
   assign bus.ovf = v_s[STAGES] & (p_q ^ sum_w[WIDTH-1] ^ c_s[STAGES]);
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized scoreboard bench for pipe_adder (32/4 and 4/2 instances).
module tb_pipe_adder;
   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        took32 = 1'b0;
   logic        hold32 = 1'b0;
   logic        hold4  = 1'b0;
   logic [32:0] last32;
   logic [4:0]  last4;
   logic [33:0] e32;
   logic [4:0]  e4;
   logic [32:0] r;
   logic        o;
   int          lat;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          n_pop4  = 0;
   int          p;
   logic [33:0] q32[$];
   logic [4:0]  q4[$];
   int          acc_cyc[$];
   int          pop_cyc[$];

   pipe_adder_if #(.WIDTH(32)) b32 ();
   pipe_adder_if #(.WIDTH(4))  b4 ();

   pipe_adder #(.WIDTH(32), .STAGES(4)) u_add32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   pipe_adder #(.WIDTH(4),  .STAGES(2)) u_add4  (.clk(clk), .rst_n(rst_n), .bus(b4));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic c);
      longint s = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      longint u = longint'(a) + longint'(b) + longint'(c);
      return {s > 64'sd2147483647 || s < -64'sd2147483648, u[32:0]};
   endfunction

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         q32.delete();
         q4.delete();
         hold32 = 1'b0;
         hold4  = 1'b0;
      end else begin
         if (hold32) check("hold32", {b32.out_valid, b32.c_out, b32.sum}, {1'b1, last32});
         if (hold4) check("hold4", {b4.out_valid, b4.c_out, b4.sum}, {1'b1, last4});
         hold32 = b32.out_valid && !b32.out_ready;
         hold4  = b4.out_valid && !b4.out_ready;
         last32 = {b32.c_out, b32.sum};
         last4  = {b4.c_out, b4.sum};
         if (b32.in_valid && b32.in_ready) begin
            q32.push_back(ref32(b32.a, b32.b, b32.c_in));
            acc_cyc.push_back(cyc);
         end
         if (b32.out_valid && b32.out_ready) begin
            pop_cyc.push_back(cyc);
            if (q32.size() == 0) check("spur32", b32.out_valid, 0);
            else begin
               e32 = q32.pop_front();
               check("sb32", {b32.c_out, b32.sum}, e32[32:0]);
`ifdef PIPE_ADDER_OVF_EN
               check("sb32_ovf", b32.ovf, e32[33]);
`endif
            end
         end
         if (b4.in_valid && b4.in_ready)
            q4.push_back(5'(int'(b4.a) + int'(b4.b) + int'(b4.c_in)));
         if (b4.out_valid && b4.out_ready) begin
            n_pop4++;
            if (q4.size() == 0) check("spur4", b4.out_valid, 0);
            else begin
               e4 = q4.pop_front();
               check("sb4", {b4.c_out, b4.sum}, e4);
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         b32.in_valid  = 1'b0;
         b4.in_valid   = 1'b0;
         b32.out_ready = 1'b1;
         b4.out_ready  = 1'b1;
      end
   endtask

   task automatic run32(input int n, input logic ordy);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (!b32.in_valid || took32) begin
            b32.a    = $urandom;
            b32.b    = $urandom;
            b32.c_in = 1'($urandom);
         end
         b32.in_valid  = 1'b1;
         b32.out_ready = ordy;
         @(negedge clk);
         took32 = b32.in_valid && b32.in_ready;
      end
   endtask

   task automatic dir32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output logic [32:0] res, output logic ov, output int n);
      @(posedge clk);
      #1;
      b32.a = a;
      b32.b = b;
      b32.c_in = c;
      b32.in_valid = 1'b1;
      b32.out_ready = 1'b1;
      @(negedge clk);
      check("dir32_rdy", b32.in_ready, 1);
      @(posedge clk);
      #1;
      b32.in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!b32.out_valid && n < 12) begin
         @(negedge clk);
         n++;
      end
      res = {b32.c_out, b32.sum};
      ov = 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      ov = b32.ovf;
`endif
   endtask

   task automatic exh4();
      int idx = 0;
      int guard = 0;
      while (idx < 512 && guard < 6000) begin
         @(posedge clk);
         #1;
         {b4.a, b4.b, b4.c_in} = 9'(idx);
         b4.in_valid = 1'b1;
         b4.out_ready = 1'($urandom);
         @(negedge clk);
         if (b4.in_valid && b4.in_ready) idx++;
         guard++;
      end
      check("exh4_done", idx, 512);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      b32.in_valid = 1'b1;
      b32.a = $urandom;
      b32.b = $urandom;
      b32.c_in = 1'b1;
      b32.out_ready = 1'b1;
      b4.in_valid = 1'b1;
      b4.a = 4'hF;
      b4.b = 4'h3;
      b4.c_in = 1'b1;
      b4.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ov32", b32.out_valid, 0);
      check("rst_sum32", b32.sum, 0);
      check("rst_cout32", b32.c_out, 0);
      check("rst_rdy32", b32.in_ready, 1);
      check("rst_ov4", b4.out_valid, 0);
      check("rst_rdy4", b4.in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
      check("rst_ovf32", b32.ovf, 0);
`endif
      @(posedge clk);
      #1;
      b32.in_valid = 1'b0;
      b4.in_valid = 1'b0;
      rst_n = 1'b1;
      idle(6);
      @(negedge clk);
      check("idle_ov32", b32.out_valid, 0);
      check("idle_ov4", b4.out_valid, 0);
      dir32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, o, lat);
      check("ripple_lat", lat, 4);
      check("ripple_sum", r[31:0], 0);
      check("ripple_cout", r[32], 1);
      idle(3);
      dir32(32'h0, 32'h0, 1'b1, r, o, lat);
      check("cin_lat", lat, 4);
      check("cin_sum", r[31:0], 1);
      check("cin_cout", r[32], 0);
      idle(3);
`ifdef PIPE_ADDER_OVF_EN
      dir32(32'h7FFF_FFFF, 32'h1, 1'b0, r, o, lat);
      check("ovf_pos", o, 1);
      check("ovf_pos_cout", r[32], 0);
      idle(3);
      dir32(32'h8000_0000, 32'h8000_0000, 1'b0, r, o, lat);
      check("ovf_neg", o, 1);
      check("ovf_neg_cout", r[32], 1);
      check("ovf_neg_sum", r[31:0], 0);
      idle(3);
      dir32(32'hFFFF_FFFF, 32'h1, 1'b0, r, o, lat);
      check("ovf_none", o, 0);
      idle(3);
`endif
      acc_cyc.delete();
      pop_cyc.delete();
      run32(8, 1'b1);
      idle(8);
      #1;
      check("str_n", pop_cyc.size(), 8);
      for (int i = 0; i < pop_cyc.size() && i < 8; i++)
         check("str_cyc", pop_cyc[i], acc_cyc[0] + 4 + i);
      acc_cyc.delete();
      pop_cyc.delete();
      run32(10, 1'b0);
      #1;
      check("stall_acc", acc_cyc.size(), 4);
      check("stall_rdy", b32.in_ready, 0);
      check("stall_pop", pop_cyc.size(), 0);
      run32(1, 1'b1);
      check("push_pop_rdy", took32, 1);
      run32(5, 1'b1);
      idle(8);
      #1;
      check("drain_acc", acc_cyc.size(), 10);
      check("drain_pop", pop_cyc.size(), 10);
      check("drain_empty", q32.size(), 0);
      if (acc_cyc.size() > 4 && pop_cyc.size() > 0) check("push_pop_cyc", pop_cyc[0], acc_cyc[4]);
      p = n_pop4;
      exh4();
      idle(8);
      #1;
      check("exh4_pops", n_pop4 - p, 512);
      check("exh4_empty", q4.size(), 0);
      @(posedge clk);
      #1;
      b4.a = 4'h3;
      b4.b = 4'h5;
      b4.c_in = 1'b1;
      b4.in_valid = 1'b1;
      b4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b4.a = 4'h9;
      b4.b = 4'h9;
      b4.c_in = 1'b0;
      @(posedge clk);
      #1;
      b4.in_valid = 1'b0;
      #1;
      check("pre_rst_ov4", b4.out_valid, 1);
      p = n_pop4;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov4", b4.out_valid, 0);
      check("mid_rst_rdy4", b4.in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(6);
      @(negedge clk);
      #1;
      check("stale_pop4", n_pop4 - p, 0);
      check("stale_ov4", b4.out_valid, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder with carry-in/carry-out and a valid/ready stream interface on both sides. A WIDTH-bit addition is split into STAGES equal slices; slice k is added in pipeline stage k, and its carry is registered into stage k+1. It replaces single-cycle combinational full-adder chains in datapaths whose carry chain would otherwise limit clock frequency.

## Interface
- WIDTH, 32, operand and sum width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages (= latency); 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0, else elaboration error.

- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  adder accepts beat this cycle.
- a  input  WIDTH  operand A, unsigned (two's complement with overflow option).
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- SLICE = WIDTH/STAGES. Stage k (0..STAGES-1) holds: valid bit v[k], carry, completed low sum bits, and the not-yet-added upper operand bits.
- Stage 0 load: adds a[SLICE-1:0] + b[SLICE-1:0] + c_in; registers slice sum, carry, and a/b upper bits.
- Stage k: adds its operand slice plus registered carry from stage k-1; appends result above prior slices; drops consumed operand bits.
- Output stage = stage STAGES-1: sum and c_out driven directly from its registers.
- Transfer on a port occurs when valid && ready in the same cycle.
- Per-stage ready, bubble-collapsing: rdy[k] = !v[k] || rdy[k+1]; rdy[STAGES] = out_ready; in_ready = rdy[0]. Stage k captures from k-1 when rdy[k]; v[k] ← v[k-1] on capture.
- Stalled stage holds all registers unchanged; out_valid/sum/c_out stable while out_valid && !out_ready.
- Results leave in acceptance order; no drop, no duplication.
- in_valid with !in_ready: beat not taken; upstream must hold.

## Timing
- Reset (async assert, sync-deassert expected upstream): all v[k]=0, all data registers 0; out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1 (combinational from v[0]).
- Latency: beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES if no stall.
- Throughput: one beat per cycle with out_ready held 1.
- Capacity: STAGES beats in flight; with out_ready=0 in_ready falls after STAGES acceptances.
- Simultaneous output pop and input push on full pipe: allowed, in_ready=1 that cycle (ready path is combinational from out_ready).
- STAGES=1: single register stage, latency 1.
- Reset mid-operation: in-flight beats discarded; out_valid=0 in same cycle as rst_n falls.

## Configuration
- PIPE_ADDER_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR c_out of MSB, pipelined with final stage, valid when out_valid; 0 otherwise.
- Not defined: no ovf port, no MSB carry-in register; behaviour otherwise identical.

## Structure
- pipe_adder_pkg: slice width function/constant derivation and stage-index helpers, shared with future pipelined subtract/compare blocks.
- One sub-module: pipe_adder_stage (one slice: slice add, carry register, valid/ready bookkeeping), instantiated STAGES times by generate.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1 -> out_valid=0, sum=0, c_out=0, in_ready=1; nothing emerges after release until a beat is accepted.
- WIDTH=32 STAGES=4: a=FFFF_FFFF, b=0000_0001, c_in=0 -> 4 cycles later sum=0000_0000, c_out=1 (carry through all slices); a=0, b=0, c_in=1 -> sum=1, c_out=0.
- Stream 8 random beats back-to-back, out_ready=1 -> 8 results on consecutive cycles starting 4 cycles after first, order and values match model.
- out_ready=0 for 10 cycles while in_valid=1 -> exactly 4 accepted, in_ready=0 after; results stable; out_ready=1 -> all 4 drained in order, new beats accepted same cycle as pops.
- WIDTH=4 STAGES=2 exhaustive 512 (a,b,c_in) with random out_ready -> every {c_out,sum} equals a+b+c_in; reset mid-stream with 2 in flight -> out_valid=0 immediately, no stale result later.
- With PIPE_ADDER_OVF_EN, WIDTH=32: a=7FFF_FFFF, b=1 -> ovf=1, c_out=0; a=8000_0000, b=8000_0000 -> ovf=1, c_out=1, sum=0; a=FFFF_FFFF, b=1 -> ovf=0.
